// File: rtl/mixed_width_sdp_ram.sv
// Simple dual-port RAM with independent write and read widths, stored as lanes
// of the narrower width, with per-lane write enables and a configurable read pipeline.
module mixed_width_sdp_ram #(
    parameter int    DATA_W    = 32,
    parameter int    DATA_R    = 8,
    parameter int    DEPTH_W   = 8,
    parameter int    DEPTH_R   = 10,
    parameter int    DELAY     = 0,
    parameter int    COLL_MODE = 0,
    parameter string INIT_FILE = "",
    localparam int   N_W       = (DATA_W < DATA_R) ? DATA_W : DATA_R,
    localparam int   WL        = DATA_W / N_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wren,
    input  logic [DEPTH_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic [WL-1:0]      i_wbe,
    input  logic               i_rden,
    input  logic [DEPTH_R-1:0] i_raddr,
    output logic [DATA_R-1:0]  o_rdata,
    output logic               o_rvalid
);

    localparam int RL     = DATA_R / N_W;
    localparam int WL_LOG = $clog2(WL);
    localparam int RL_LOG = $clog2(RL);
    localparam int LA     = DEPTH_W + WL_LOG;
    localparam int NLANES = (2 ** DEPTH_W) * WL;
    localparam int RATIO  = (DATA_W > DATA_R) ? DATA_W / DATA_R : DATA_R / DATA_W;
    localparam int REM    = (DATA_W > DATA_R) ? DATA_W % DATA_R : DATA_R % DATA_W;

    // Both port geometries must describe the same lane array.
    generate
        if (DATA_W * (2 ** DEPTH_W) != DATA_R * (2 ** DEPTH_R)) begin : g_errSize
            $error("mixed_width_sdp_ram: DATA_W*2**DEPTH_W must equal DATA_R*2**DEPTH_R");
        end
        if ((1 << $clog2(RATIO)) != RATIO) begin : g_errPow2
            $error("mixed_width_sdp_ram: width ratio must be a power of two");
        end
        if (REM != 0) begin : g_errMult
            $error("mixed_width_sdp_ram: larger width must be a multiple of the smaller");
        end
    endgenerate

    logic [N_W-1:0] mem [NLANES];

    // Array starts cleared.
    initial for (int i = 0; i < NLANES; i++) mem[i] = '0;

    logic [LA-1:0] wBase;
    logic [LA-1:0] rBase;

    assign wBase = LA'(i_waddr) << WL_LOG;
    assign rBase = LA'(i_raddr) << RL_LOG;

    // Array write; the array itself is never touched by reset.
    always @(posedge clk) begin
        if (!rst && i_wren) begin
            for (int k = 0; k < WL; k++) begin
                if (i_wbe[k]) begin
                    mem[wBase + LA'(k)] <= i_wdata[k*N_W +: N_W];
                end
            end
        end
    end

    // Read lanes; write-first mode forwards same-edge written lanes.
    logic [DATA_R-1:0] rdLanes_d;

    always_comb begin
        rdLanes_d = '0;
        for (int j = 0; j < RL; j++) begin
            rdLanes_d[j*N_W +: N_W] = mem[rBase + LA'(j)];
            if (COLL_MODE == 1 && i_wren && !rst) begin
                for (int k = 0; k < WL; k++) begin
                    if (i_wbe[k] && ((wBase + LA'(k)) == (rBase + LA'(j)))) begin
                        rdLanes_d[j*N_W +: N_W] = i_wdata[k*N_W +: N_W];
                    end
                end
            end
        end
    end

    // Stage 0 is the array register; each stage only loads on a valid so data holds.
    logic [DATA_R-1:0] data_q [DELAY+1];
    logic [DELAY:0]    valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i <= DELAY; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= i_rden;
            if (i_rden) data_q[0] <= rdLanes_d;
            for (int i = 1; i <= DELAY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign o_rdata  = data_q[DELAY];
    assign o_rvalid = valid_q[DELAY];

endmodule
